// File: rtl/palette_colorizer.sv
// rtl/palette_colorizer.sv - 8-entry writable palette colourizer with icon blink and 2-stage pixel pipeline
module palette_colorizer #(
    parameter int RW           = 3,
    parameter int GW           = 3,
    parameter int BW           = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  i_clock,
    input  logic                  i_rst,
    input  logic                  i_video_on,
    input  logic [1:0]            i_world_pixel,
    input  logic [1:0]            i_icon,
    input  logic                  i_frame_tick,
    input  logic                  i_blink_en,
    input  logic                  i_pal_wr_en,
    input  logic [2:0]            i_pal_wr_addr,
    input  logic [RW+GW+BW-1:0]   i_pal_wr_data,
    output logic                  o_pal_wr_ack,
    output logic [RW-1:0]         o_red,
    output logic [GW-1:0]         o_green,
    output logic [BW-1:0]         o_blue,
    output logic                  o_video_on_out
);

    localparam int CW = RW + GW + BW;

    localparam logic [RW-1:0] R_ONES = '1;
    localparam logic [GW-1:0] G_ONES = '1;
    localparam logic [BW-1:0] B_ONES = '1;
    localparam logic [RW-1:0] R_ZERO = '0;
    localparam logic [GW-1:0] G_ZERO = '0;
    localparam logic [BW-1:0] B_ZERO = '0;
    localparam logic [RW-1:0] R_MSB  = ~(R_ONES >> 1);
    localparam logic [GW-1:0] G_MSB  = ~(G_ONES >> 1);
    localparam logic [BW-1:0] B_MSB  = ~(B_ONES >> 1);
    localparam logic [7:0]    BLINK_LAST = 8'(BLINK_FRAMES - 1);

    function automatic logic [CW-1:0] reset_entry(input logic [2:0] a);
        case (a)
            3'd0:    reset_entry = {R_ONES, G_ONES, B_ONES};
            3'd2:    reset_entry = {R_ONES, G_ZERO, B_ZERO};
            3'd3:    reset_entry = {R_MSB,  G_MSB,  B_MSB};
            3'd4:    reset_entry = {R_MSB,  G_ZERO, B_ZERO};
            3'd5:    reset_entry = {R_ZERO, G_ONES, B_ONES};
            3'd6:    reset_entry = {R_ONES, G_ZERO, B_ONES};
            default: reset_entry = '0;
        endcase
    endfunction

    logic [CW-1:0] r_pal [8];
    logic          r_ack;
    logic [7:0]    r_blink_cnt;
    logic          r_blink_phase;
    logic          r_s1_video_on;
    logic [2:0]    r_s1_idx;
    logic [RW-1:0] r_red;
    logic [GW-1:0] r_green;
    logic [BW-1:0] r_blue;
    logic          r_video_on_out;

    logic          w_suppress;
    logic [2:0]    w_idx;
    logic [CW-1:0] w_entry;

    // Blanking wins, then a visible icon, then the map underneath.
    assign w_suppress = i_blink_en & r_blink_phase;
    always_comb begin
        w_idx = {1'b0, i_world_pixel};
        if (!i_video_on) begin
            w_idx = 3'd7;
        end else if (i_icon != 2'd0 && !w_suppress) begin
            w_idx = 3'd3 + {1'b0, i_icon};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            for (int i = 0; i < 8; i++) begin
                r_pal[i] <= reset_entry(3'(i));
            end
            r_ack <= 1'b0;
        end else begin
            if (i_pal_wr_en) begin
                r_pal[i_pal_wr_addr] <= i_pal_wr_data;
            end
            r_ack <= i_pal_wr_en;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_rst || !i_blink_en) begin
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= 1'b0;
        end else if (i_frame_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= 8'd0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end

    // Stage 2 reads the palette before any same-edge write lands.
    assign w_entry = r_pal[r_s1_idx];

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_s1_video_on  <= 1'b0;
            r_s1_idx       <= 3'd0;
            r_red          <= '0;
            r_green        <= '0;
            r_blue         <= '0;
            r_video_on_out <= 1'b0;
        end else begin
            r_s1_video_on  <= i_video_on;
            r_s1_idx       <= w_idx;
            r_red          <= w_entry[CW-1:GW+BW];
            r_green        <= w_entry[GW+BW-1:BW];
            r_blue         <= w_entry[BW-1:0];
            r_video_on_out <= r_s1_video_on;
        end
    end

    assign o_pal_wr_ack   = r_ack;
    assign o_red          = r_red;
    assign o_green        = r_green;
    assign o_blue         = r_blue;
    assign o_video_on_out = r_video_on_out;

endmodule

// File: tb/tb_palette_colorizer.sv
// tb/tb_palette_colorizer.sv - randomized and directed checks of palette_colorizer against a frame-level model
module tb_palette_colorizer;

    localparam int BF = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       von = 1'b0;
    logic [1:0] wp = 2'd0;
    logic [1:0] ic = 2'd0;
    logic       ft = 1'b0;
    logic       be = 1'b0;
    logic       we = 1'b0;
    logic [2:0] wa = 3'd0;
    logic [7:0] wd = 8'd0;

    logic       ack;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic       vo;

    logic        x_we = 1'b0;
    logic [15:0] x_wd = 16'd0;
    logic        x_ack;
    logic [4:0]  x_red;
    logic [5:0]  x_green;
    logic [4:0]  x_blue;
    logic        x_vo;

    palette_colorizer #(.RW(3), .GW(3), .BW(2), .BLINK_FRAMES(BF)) u_dut (
        .i_clock(clk), .i_rst(rst), .i_video_on(von), .i_world_pixel(wp), .i_icon(ic),
        .i_frame_tick(ft), .i_blink_en(be), .i_pal_wr_en(we), .i_pal_wr_addr(wa),
        .i_pal_wr_data(wd), .o_pal_wr_ack(ack), .o_red(red), .o_green(green),
        .o_blue(blue), .o_video_on_out(vo)
    );

    palette_colorizer #(.RW(5), .GW(6), .BW(5)) u_wide (
        .i_clock(clk), .i_rst(rst), .i_video_on(von), .i_world_pixel(wp), .i_icon(ic),
        .i_frame_tick(ft), .i_blink_en(be), .i_pal_wr_en(x_we), .i_pal_wr_addr(wa),
        .i_pal_wr_data(x_wd), .o_pal_wr_ack(x_ack), .o_red(x_red), .o_green(x_green),
        .o_blue(x_blue), .o_video_on_out(x_vo)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] m_pal [8];
    int         m_ticks = 0;
    logic [2:0] m_idx = 3'd0;
    logic       m_von = 1'b0;
    logic [7:0] exp_rgb;
    logic       exp_von;
    logic       exp_ack;
    logic [7:0] rgb;

    assign rgb = {red, green, blue};

    function automatic logic [7:0] reset_val(input int a);
        case (a)
            0: reset_val = 8'hFF;
            2: reset_val = 8'hE0;
            3: reset_val = 8'h92;
            4: reset_val = 8'h80;
            5: reset_val = 8'h1F;
            6: reset_val = 8'hE3;
            default: reset_val = 8'h00;
        endcase
    endfunction

    // One clock of stimulus; the model predicts what the outputs show just after this edge.
    task automatic step(input logic t_von, input logic [1:0] t_wp, input logic [1:0] t_ic,
                        input logic t_ft, input logic t_be, input logic t_we,
                        input logic [2:0] t_wa, input logic [7:0] t_wd, input logic t_rst);
        logic [2:0] idx;
        logic       supp;
        rst = t_rst; von = t_von; wp = t_wp; ic = t_ic; ft = t_ft; be = t_be;
        we = t_we; wa = t_wa; wd = t_wd;
        supp = t_be && (((m_ticks / BF) % 2) == 1);
        if (!t_von) idx = 3'd7;
        else if (t_ic != 2'd0 && !supp) idx = 3'd3 + {1'b0, t_ic};
        else idx = {1'b0, t_wp};
        @(posedge clk);
        if (t_rst) begin
            exp_rgb = 8'h00; exp_von = 1'b0; exp_ack = 1'b0;
            for (int i = 0; i < 8; i++) m_pal[i] = reset_val(i);
            m_ticks = 0; m_idx = 3'd0; m_von = 1'b0;
        end else begin
            exp_rgb = m_pal[m_idx]; exp_von = m_von; exp_ack = t_we;
            if (t_we) m_pal[t_wa] = t_wd;
            m_idx = idx; m_von = t_von;
            if (!t_be) m_ticks = 0;
            else if (t_ft) m_ticks = (m_ticks + 1) % (2 * BF);
        end
        #1;
    endtask

    task automatic pix(input logic t_von, input logic [1:0] t_wp, input logic [1:0] t_ic);
        step(t_von, t_wp, t_ic, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
        step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b1);
        step(1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b1);
        n_total++;
        if (rgb !== 8'h00 || vo !== 1'b0 || ack !== 1'b0)
            $display("FAIL reset_outputs: got rgb=%h vo=%b ack=%b expected 00/0/0", rgb, vo, ack);
        else n_pass++;
        pix(1'b0, 2'd0, 2'd0);
        n_total++;
        if (ack !== 1'b0) $display("FAIL reset_write_ack: got %b expected 0", ack);
        else n_pass++;
    endtask

    task automatic test_sweep();
        logic [7:0] tbl [16];
        for (int i = 0; i < 16; i++)
            tbl[i] = (i % 4 == 0) ? reset_val(i / 4) : reset_val(3 + (i % 4));
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) pix(1'b1, 2'(i / 4), 2'(i % 4));
            else pix(1'b1, 2'd0, 2'd0);
            if (i > 0) begin
                n_total++;
                if (rgb !== tbl[i-1] || vo !== 1'b1)
                    $display("FAIL sweep_code%0d: got rgb=%h vo=%b expected %h/1", i - 1, rgb, vo, tbl[i-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_blanking();
        for (int i = 0; i <= 5; i++) begin
            pix(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if (i > 1) begin
                n_total++;
                if (rgb !== 8'h00 || vo !== 1'b0)
                    $display("FAIL blanking: got rgb=%h vo=%b expected 00/0", rgb, vo);
                else n_pass++;
            end
        end
    endtask

    task automatic test_write_collision();
        do_reset();
        pix(1'b1, 2'd0, 2'd0);
        step(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h1C, 1'b0);
        n_total++;
        if (rgb !== 8'hFF || ack !== 1'b1)
            $display("FAIL collision_old: got rgb=%h ack=%b expected FF/1", rgb, ack);
        else n_pass++;
        pix(1'b1, 2'd0, 2'd0);
        n_total++;
        if (rgb !== 8'h1C || ack !== 1'b0)
            $display("FAIL collision_new: got rgb=%h ack=%b expected 1C/0", rgb, ack);
        else n_pass++;
        pix(1'b1, 2'd0, 2'd0);
        n_total++;
        if (rgb !== 8'h1C) $display("FAIL write_persist: got %h expected 1C", rgb);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d[i] = 8'($urandom);
            step(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'(4 + i), d[i], 1'b0);
            n_total++;
            if (ack !== 1'b1) $display("FAIL b2b_ack%0d: got %b expected 1", i, ack);
            else n_pass++;
        end
        for (int i = 0; i <= 3; i++) begin
            pix(1'b1, 2'd2, (i < 3) ? 2'(i + 1) : 2'd0);
            if (i > 0) begin
                n_total++;
                if (rgb !== d[i-1]) $display("FAIL b2b_read%0d: got %h expected %h", i - 1, rgb, d[i-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] want [6];
        want = '{8'h80, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'hFF};
        do_reset();
        step(1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
        step(1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
        step(1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
        n_total++;
        if (rgb !== 8'h80) $display("FAIL blink_start: got %h expected 80", rgb);
        else n_pass++;
        for (int t = 0; t < 6; t++) begin
            step(1'b1, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
            step(1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
            step(1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
            n_total++;
            if (rgb !== want[t]) $display("FAIL blink_tick%0d: got %h expected %h", t + 1, rgb, want[t]);
            else n_pass++;
        end
        step(1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
        step(1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
        n_total++;
        if (rgb !== 8'h80) $display("FAIL blink_disable: got %h expected 80", rgb);
        else n_pass++;
    endtask

    task automatic test_wide();
        do_reset();
        pix(1'b1, 2'd3, 2'd0);
        pix(1'b1, 2'd0, 2'd3);
        n_total++;
        if (x_red !== 5'h10 || x_green !== 6'h20 || x_blue !== 5'h10)
            $display("FAIL wide_world3: got %h/%h/%h expected 10/20/10", x_red, x_green, x_blue);
        else n_pass++;
        pix(1'b1, 2'd0, 2'd0);
        n_total++;
        if (x_red !== 5'h1F || x_green !== 6'h00 || x_blue !== 5'h1F)
            $display("FAIL wide_icon3: got %h/%h/%h expected 1F/00/1F", x_red, x_green, x_blue);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 3'd5, 8'h55, 1'b0);
        pix(1'b1, 2'd0, 2'd2);
        pix(1'b1, 2'd0, 2'd2);
        n_total++;
        if (rgb !== 8'h55) $display("FAIL mid_written: got %h expected 55", rgb);
        else n_pass++;
        step(1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 3'd5, 8'h66, 1'b1);
        n_total++;
        if (rgb !== 8'h00 || vo !== 1'b0 || ack !== 1'b0)
            $display("FAIL mid_reset: got rgb=%h vo=%b ack=%b expected 00/0/0", rgb, vo, ack);
        else n_pass++;
        pix(1'b1, 2'd0, 2'd2);
        pix(1'b1, 2'd0, 2'd2);
        pix(1'b1, 2'd0, 2'd2);
        n_total++;
        if (rgb !== 8'h1F || ack !== 1'b0)
            $display("FAIL mid_restored: got rgb=%h ack=%b expected 1F/0", rgb, ack);
        else n_pass++;
    endtask

    task automatic test_random();
        logic r_be;
        r_be = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) r_be = ~r_be;
            step($urandom_range(0, 7) != 0, 2'($urandom), 2'($urandom),
                 $urandom_range(0, 2) == 0, r_be, $urandom_range(0, 3) == 0,
                 3'($urandom), 8'($urandom), $urandom_range(0, 49) == 0);
            n_total++;
            if (rgb !== exp_rgb || vo !== exp_von || ack !== exp_ack) begin
                if (n_total - n_pass < 10)
                    $display("FAIL random_cycle%0d: got rgb=%h vo=%b ack=%b expected %h/%b/%b",
                             i, rgb, vo, ack, exp_rgb, exp_von, exp_ack);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_blanking();
        test_write_collision();
        test_back_to_back();
        test_blink();
        test_wide();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/palette_colorizer.md
PALETTE_COLORIZER -- requirements
Module: palette_colorizer

Interface
REQ-001 Parameter RW, default 3: red channel width in bits.
REQ-002 Parameter GW, default 3: green channel width in bits.
REQ-003 Parameter BW, default 2: blue channel width in bits; CW = RW+GW+BW.
REQ-004 Parameter BLINK_FRAMES, default 30: number of frame_tick pulses per blink half-period, legal range 1..255.
REQ-005 clock  in  1  system pixel clock; every register is clocked on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 video_on  in  1  1 = active video area, 0 = blanking.
REQ-008 world_pixel  in  2  map pixel code: 0 = background, 1 = line, 2 = obstruction, 3 = reserved.
REQ-009 icon  in  2  icon pixel code: 0 = transparent, 1..3 = icon colours 1..3.
REQ-010 frame_tick  in  1  one-cycle pulse, once per frame.
REQ-011 blink_en  in  1  1 = icon pixels blink.
REQ-012 pal_wr_en  in  1  palette write strobe; one entry per asserted cycle.
REQ-013 pal_wr_addr  in  3  palette entry index, 0..7.
REQ-014 pal_wr_data  in  CW  new entry value, packed as {red, green, blue}.
REQ-015 pal_wr_ack  out  1  one-cycle pulse acknowledging a write.
REQ-016 red  out  RW  registered red channel.
REQ-017 green  out  GW  registered green channel.
REQ-018 blue  out  BW  registered blue channel.
REQ-019 video_on_out  out  1  video_on delayed to align with the colour outputs.

Function
REQ-020 The palette SHALL hold 8 registered CW-bit entries with these roles:
  - 0..3: world colours for world_pixel 0..3.
  - 4..6: icon colours for icon 1..3.
  - 7: blanking colour.
REQ-021 Pixel pipeline SHALL have exactly 2 stages:
  - Edge N: register video_on, world_pixel, icon and the computed palette index.
  - Edge N+1: register the palette lookup onto red/green/blue and video_on_out.
REQ-022 Index select SHALL use the first matching rule:
  - video_on = 0 -> 7.
  - icon != 0 and not blink-suppressed -> 3 + icon.
  - otherwise -> world_pixel.
REQ-023 Icon SHALL be blink-suppressed when blink_en = 1 and blink_phase = 1; the world colour for that world_pixel is then shown.
REQ-024 Blink counter (8 bits) SHALL increment on each frame_tick while blink_en = 1. On the tick where it equals BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-025 While blink_en = 0, the blink counter and blink_phase SHALL be held at 0.
REQ-026 A write with pal_wr_en = 1 at edge N SHALL update entry pal_wr_addr at edge N and pulse pal_wr_ack high for the cycle following edge N.
REQ-027 Back-to-back writes on consecutive cycles SHALL each be accepted and acknowledged; there is no backpressure.
REQ-028 Read/write collision: a stage-2 lookup at edge N of the entry being written at edge N SHALL output the old value; lookups at edge N+1 onward SHALL see the new value.
REQ-029 Output packing SHALL be red = entry[CW-1:GW+BW], green = entry[GW+BW-1:BW], blue = entry[BW-1:0].
REQ-030 No input combination SHALL produce X on any output; all 16 {world_pixel, icon} codes are covered by REQ-022.

Reset
REQ-031 While rst = 1, red, green, blue, video_on_out and pal_wr_ack SHALL be 0, and both pipeline stages, the blink counter and blink_phase SHALL be cleared.
REQ-032 Reset SHALL load the palette as follows (MSB = channel MSB set, others 0):
  - 0: all ones (white).
  - 1: all zeros (black).
  - 2: red all ones (red).
  - 3: red, green and blue MSB only (grey).
  - 4: red MSB only (maroon).
  - 5: green and blue all ones (cyan).
  - 6: red and blue all ones (magenta).
  - 7: all zeros.
REQ-033 A write issued in the same cycle as rst = 1 SHALL be discarded and SHALL NOT be acknowledged.
REQ-034 Reset asserted mid-frame SHALL override all in-flight pixels from the next edge.

Verification
REQ-035 Default parameters, after reset, video_on = 1, sweep all 16 {world_pixel, icon} codes:
  - outputs after 2 edges: 0/0 -> FF; 1/0 -> 00; 2/0 -> E0; 3/0 -> 92; x/1 -> 80; x/2 -> 1F; x/3 -> E3.
REQ-036 video_on = 0 with any pixel code -> output 00 and video_on_out = 0 two edges later.
REQ-037 Write addr 0, data 8'h1C:
  - pal_wr_ack pulses for exactly 1 cycle.
  - World code 0 then outputs 1C, with the same-edge collision showing old FF per REQ-028.
REQ-038 BLINK_FRAMES = 2, blink_en = 1, icon = 1 over world 0:
  - Output is 80 for 2 frame_ticks, FF for the next 2, then 80 again.
  - Deasserting blink_en restores 80 immediately.
REQ-039 Write addr 5 then assert rst -> entry 5 returns to 1F, and all outputs read 0 during reset.
REQ-040 RW=5, GW=6, BW=5 build: icon 3 -> red 1F, green 00, blue 1F; world 3 -> red 10, green 20, blue 10.
